axi_read_streamer: RTL and testbench

AXI_READ_STREAMER -- requirements
Module: axi_read_streamer

---
 rtl/slime_axi_pkg.sv | 15 +
 rtl/stream_fifo.sv | 59 +++++
 rtl/axi_read_streamer.sv | 162 ++++++++++++++++
 tb/tb_axi_read_streamer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slime_axi_pkg.sv
// Shared AXI streaming definitions: streamer FSM states and word-size helper.
package slime_axi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned BYTES_PER_WORD(input int unsigned data_bits);
        return data_bits / 8;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Power-of-two valid/ready FIFO; a push and a pop may share a cycle at any occupancy.
module stream_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PtrBits = $clog2(DEPTH);
    localparam int unsigned CntBits = $clog2(DEPTH + 1);
    localparam logic [CntBits-1:0] FullCount = CntBits'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PtrBits-1:0] rd_ptr;
    logic [PtrBits-1:0] wr_ptr;
    logic               push;
    logic               pop;

    assign out_valid = (count != '0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready  = (count != FullCount) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_streamer.sv
// Fetches word_count consecutive words over AXI AR/R and streams them out in order.
// Defining AXI_READ_STREAMER_PERF_EN adds a saturating stall_cycles counter output.
module axi_read_streamer
    import slime_axi_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 17,
    parameter int unsigned DATA_BITS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [15:0]          word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    output logic [ADDR_BITS-1:0] axi_araddr,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic [DATA_BITS-1:0] axi_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data
`ifdef AXI_READ_STREAMER_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int unsigned CntBits    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CreditBits = CntBits + 1;
    localparam logic [CreditBits-1:0] DepthCredit = CreditBits'(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0]  AddrStep    = ADDR_BITS'(BYTES_PER_WORD(DATA_BITS));

    state_e               state;
    logic [15:0]          remaining;
    logic [CntBits-1:0]   outstanding;
    logic [CntBits-1:0]   outstanding_next;
    logic [CntBits-1:0]   fifo_count;
    logic [CntBits-1:0]   count_next;
    logic [CreditBits-1:0] credit_next;
    logic                 ar_hs;
    logic                 r_hs;
    logic                 pop;
    logic                 fifo_in_ready;
    logic                 credit_ok;

    assign axi_rready = busy;
    assign ar_hs      = axi_arvalid && axi_arready;
    assign r_hs       = axi_rvalid && busy;
    assign pop        = out_valid && out_ready;

    // Credit is judged on next-cycle totals so a registered arvalid never overcommits.
    always_comb begin
        outstanding_next = outstanding;
        if (ar_hs && !r_hs) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!ar_hs && r_hs) begin
            outstanding_next = outstanding - 1'b1;
        end
        count_next = fifo_count;
        if (r_hs && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!r_hs && pop) begin
            count_next = fifo_count - 1'b1;
        end
        credit_next = CreditBits'(outstanding_next) + CreditBits'(count_next);
    end

    assign credit_ok = (credit_next < DepthCredit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            remaining   <= '0;
            outstanding <= '0;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_next;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        axi_araddr <= base_addr;
                        remaining  <= word_count;
                        busy       <= 1'b1;
                        if (word_count == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state       <= StIssue;
                            axi_arvalid <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (ar_hs) begin
                        axi_araddr <= axi_araddr + AddrStep;
                        remaining  <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state       <= StDrain;
                            axi_arvalid <= 1'b0;
                        end else begin
                            axi_arvalid <= credit_ok;
                        end
                    end else if (!axi_arvalid) begin
                        axi_arvalid <= credit_ok;
                    end
                end
                StDrain: begin
                    if (outstanding_next == '0 && count_next == '0) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (r_hs),
        .in_ready  (fifo_in_ready),
        .in_data   (axi_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_count)
    );

    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        r_hs |-> fifo_in_ready);

`ifdef AXI_READ_STREAMER_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == StIdle && start) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_read_streamer.sv
// Directed and randomized bench for axi_read_streamer with an AXI read slave responder.
module tb_axi_read_streamer;
    localparam int unsigned ADDR_BITS  = 17;
    localparam int unsigned DATA_BITS  = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [ADDR_BITS-1:0] base_addr = '0;
    logic [15:0]          word_count = '0;
    logic                 busy;
    logic                 done;
    logic                 axi_arvalid;
    logic                 axi_arready = 1'b0;
    logic [ADDR_BITS-1:0] axi_araddr;
    logic                 axi_rvalid = 1'b0;
    logic                 axi_rready;
    logic [DATA_BITS-1:0] axi_rdata = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DATA_BITS-1:0] out_data;
`ifdef AXI_READ_STREAMER_PERF_EN
    logic [31:0]          stall_cycles;
`endif

    axi_read_streamer #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef AXI_READ_STREAMER_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ar_mode = 0;   // 0 always ready, 1 random, 2 stall second AR
    int out_mode = 0;  // 0 always ready, 1 never ready, 2 random
    int r_mode = 0;    // 0 one-cycle latency, 1 random latency
    int stall_left = 0;

    logic [ADDR_BITS-1:0] slave_q[$];
    logic [ADDR_BITS-1:0] ar_log[$];
    logic [DATA_BITS-1:0] out_log[$];
    int ar_count, pop_count, stab_viol, credit_viol, held_cycles;
    int arvalid_cycles, busy_cycles, done_count, done_cyc, last_pop_cyc, start_cyc;
    bit pend_ar, pend_r, pend_pop, prev_ar_stall, prev_out_stall;
    logic [ADDR_BITS-1:0] pend_addr, prev_addr;
    logic [DATA_BITS-1:0] pend_data, prev_data;

    // Memory image seen by the slave: contents are a fixed function of the address.
    function automatic logic [DATA_BITS-1:0] mem_word(input logic [ADDR_BITS-1:0] a);
        logic [31:0] h;
        h = {15'h0, a} * 32'h9E37_79B9;
        return {a, ~a, h[29:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave responder and protocol monitor; effects of a posedge handshake are applied
    // at the following negedge, where every DUT output is settled.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            slave_q.delete();
            pend_ar = 0; pend_r = 0; pend_pop = 0;
            prev_ar_stall = 0; prev_out_stall = 0;
            axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; out_ready = 1'b0;
        end else begin
            if (pend_r) void'(slave_q.pop_front());
            if (pend_ar) begin
                slave_q.push_back(pend_addr);
                ar_log.push_back(pend_addr);
                ar_count++;
            end
            if (pend_pop) begin
                out_log.push_back(pend_data);
                pop_count++;
            end
            if (prev_ar_stall && (axi_arvalid !== 1'b1 || axi_araddr !== prev_addr)) stab_viol++;
            if (prev_out_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_viol++;
            if (axi_arvalid && (ar_count - pop_count) >= FIFO_DEPTH) credit_viol++;
            if (axi_arvalid) arvalid_cycles++;
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end

            case (ar_mode)
                0: axi_arready = 1'b1;
                1: axi_arready = 1'($urandom_range(0, 1));
                default: begin
                    if (ar_count == 1 && axi_arvalid && stall_left > 0) begin
                        axi_arready = 1'b0;
                        stall_left--;
                    end else begin
                        axi_arready = 1'b1;
                    end
                end
            endcase
            case (out_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (slave_q.size() > 0 && (r_mode == 0 || $urandom_range(0, 2) != 0)) begin
                axi_rvalid = 1'b1;
                axi_rdata  = mem_word(slave_q[0]);
            end else begin
                axi_rvalid = 1'b0;
                axi_rdata  = '0;
            end

            pend_ar   = axi_arvalid && axi_arready;
            pend_addr = axi_araddr;
            pend_r    = axi_rvalid && axi_rready;
            pend_pop  = out_valid && out_ready;
            pend_data = out_data;
            if (pend_pop) last_pop_cyc = cyc;
            prev_ar_stall  = axi_arvalid && !axi_arready;
            prev_addr      = axi_araddr;
            if (prev_ar_stall) held_cycles++;
            prev_out_stall = out_valid && !out_ready;
            prev_data      = out_data;
        end
    end

    task automatic clear_logs();
        ar_log.delete(); out_log.delete();
        ar_count = 0; pop_count = 0; stab_viol = 0; credit_viol = 0; held_cycles = 0;
        arvalid_cycles = 0; busy_cycles = 0; done_count = 0; done_cyc = -1; last_pop_cyc = -1;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic launch(input logic [ADDR_BITS-1:0] base, input logic [15:0] n);
        @(negedge clock);
        #1;
        base_addr  = base;
        word_count = n;
        start      = 1'b1;
        start_cyc  = cyc;
        @(negedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (done_count >= 1 && !busy) begin
                ok = 1;
                break;
            end
        end
        check({tag, ".finished"}, 64'(ok), 64'd1);
    endtask

    task automatic check_transfer(input string tag, input logic [ADDR_BITS-1:0] base,
                                  input int n);
        logic [ADDR_BITS-1:0] ea;
        logic [ADDR_BITS-1:0] oa;
        logic [DATA_BITS-1:0] od;
        check({tag, ".ars"}, 64'(ar_count), 64'(n));
        check({tag, ".pops"}, 64'(out_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            ea = base + ADDR_BITS'(i * 8);
            oa = (i < ar_log.size()) ? ar_log[i] : 'x;
            od = (i < out_log.size()) ? out_log[i] : 'x;
            check($sformatf("%s.araddr[%0d]", tag, i), 64'(oa), 64'(ea));
            check($sformatf("%s.data[%0d]", tag, i), od, mem_word(ea));
        end
        check({tag, ".done_pulses"}, 64'(done_count), 64'd1);
        check({tag, ".done_after_pop"}, 64'(done_cyc), 64'(last_pop_cyc + 1));
        check({tag, ".stability"}, 64'(stab_viol), 64'd0);
        check({tag, ".credit"}, 64'(credit_viol), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".arvalid"}, 64'(axi_arvalid), 64'd0);
        check({tag, ".rready"}, 64'(axi_rready), 64'd0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".araddr"}, 64'(axi_araddr), 64'd0);
        check({tag, ".out_data"}, out_data, 64'd0);
    endtask

    initial begin
        logic [ADDR_BITS-1:0] rb;
        int rn;
        bit reached;

        // Reset state
        clear_logs();
        step(3);
        check_zero_outputs("reset");
        reset = 1'b0;
        step(2);

        // Basic four-word fetch with an always-ready system
        ar_mode = 0; out_mode = 0; r_mode = 0;
        clear_logs();
        launch(17'h00100, 16'd4);
        wait_done("basic", 100);
        check_transfer("basic", 17'h00100, 4);

        // Zero-length request
        clear_logs();
        launch(17'h00200, 16'd0);
        wait_done("zero", 20);
        check("zero.ars", 64'(arvalid_cycles), 64'd0);
        check("zero.busy_cycles", 64'(busy_cycles), 64'd1);
        check("zero.done_cycle", 64'(done_cyc), 64'(start_cyc + 1));

        // Consumer stalled: credit must stop issue at FIFO_DEPTH
        clear_logs();
        out_mode = 1;
        launch(17'h00400, 16'd10);
        step(30);
        check("backpressure.ars_capped", 64'(ar_count), 64'(FIFO_DEPTH));
        check("backpressure.arvalid_low", 64'(axi_arvalid), 64'd0);
        check("backpressure.no_pops", 64'(out_log.size()), 64'd0);
        out_mode = 0;
        wait_done("backpressure", 200);
        check_transfer("backpressure", 17'h00400, 10);

        // Address wrap at the top of the 17-bit space
        clear_logs();
        launch(17'h1FFF8, 16'd2);
        wait_done("wrap", 100);
        check_transfer("wrap", 17'h1FFF8, 2);
        check("wrap.second_addr", 64'(ar_log.size() > 1 ? ar_log[1] : 'x), 64'h0);

        // AR stall on the second request plus an ignored mid-run start
        clear_logs();
        ar_mode = 2; stall_left = 3;
        launch(17'h02000, 16'd5);
        step(1);
        launch(17'h03000, 16'd9);
        wait_done("arstall", 200);
        check_transfer("arstall", 17'h02000, 5);
        check("arstall.held_cycles", 64'(held_cycles), 64'd3);
        step(5);
        check("arstall.restart_ignored", 64'(busy), 64'd0);
        ar_mode = 0;

        // Reset mid-transfer, then a clean restart
        clear_logs();
        launch(17'h05000, 16'd6);
        reached = 0;
        for (int k = 0; k < 100; k++) begin
            if (pop_count >= 2) begin
                reached = 1;
                break;
            end
            step(1);
        end
        check("midreset.reached_two", 64'(reached), 64'd1);
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        step(2);
        reset = 1'b0;
        step(2);
        clear_logs();
        launch(17'h06000, 16'd3);
        wait_done("after_reset", 100);
        check_transfer("after_reset", 17'h06000, 3);

        // Randomized handshakes and request shapes
        ar_mode = 1; out_mode = 2; r_mode = 1;
        for (int it = 0; it < 8; it++) begin
            rb = ADDR_BITS'($urandom);
            rn = $urandom_range(1, 12);
            clear_logs();
            launch(rb, 16'(rn));
            wait_done($sformatf("rnd%0d", it), 600);
            check_transfer($sformatf("rnd%0d", it), rb, rn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
